// File: rtl/easyaxi_rd_arb.sv
// ---------------------------------------------------------------------------
// easyaxi_rd_arb
// Shares one downstream AXI read port between two EASYAXI read masters.
//  - AR channel: round-robin arbitration between eligible masters. A request
//    that is presented but not yet accepted locks the grant until the
//    handshake. The forwarded ID carries the master index in its MSB.
//  - R channel: beats are routed back to a master by the ID tag bit, with no
//    buffering.
//  - Each master has its own outstanding-burst counter. A master that has
//    OST_MAX bursts outstanding is not eligible for a grant.
// Ports:
//  clk, rst_n                   clock, asynchronous active-low reset
//  m0_ar* / m1_ar*              upstream AR channels (valid/ready/payload)
//  m0_r*  / m1_r*               upstream R channels (routed valid, broadcast data)
//  s_ar*                        downstream AR channel, s_arid = {tag, arid}
//  s_r*                         downstream R channel, s_rid = {tag, rid}
// ---------------------------------------------------------------------------
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
   parameter int OST_MAX = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      m0_arvalid,
   output logic                      m0_arready,
   input  logic [`AXI_ID_W-1:0]      m0_arid,
   input  logic [`AXI_ADDR_W-1:0]    m0_araddr,
   input  logic [`AXI_LEN_W-1:0]     m0_arlen,
   input  logic [`AXI_SIZE_W-1:0]    m0_arsize,
   input  logic [`AXI_BURST_W-1:0]   m0_arburst,
   input  logic                      m1_arvalid,
   output logic                      m1_arready,
   input  logic [`AXI_ID_W-1:0]      m1_arid,
   input  logic [`AXI_ADDR_W-1:0]    m1_araddr,
   input  logic [`AXI_LEN_W-1:0]     m1_arlen,
   input  logic [`AXI_SIZE_W-1:0]    m1_arsize,
   input  logic [`AXI_BURST_W-1:0]   m1_arburst,
   output logic                      m0_rvalid,
   input  logic                      m0_rready,
   output logic [`AXI_ID_W-1:0]      m0_rid,
   output logic [`AXI_DATA_W-1:0]    m0_rdata,
   output logic [`AXI_RESP_W-1:0]    m0_rresp,
   output logic                      m0_rlast,
   output logic                      m1_rvalid,
   input  logic                      m1_rready,
   output logic [`AXI_ID_W-1:0]      m1_rid,
   output logic [`AXI_DATA_W-1:0]    m1_rdata,
   output logic [`AXI_RESP_W-1:0]    m1_rresp,
   output logic                      m1_rlast,
   output logic                      s_arvalid,
   input  logic                      s_arready,
   output logic [`AXI_ID_W:0]        s_arid,
   output logic [`AXI_ADDR_W-1:0]    s_araddr,
   output logic [`AXI_LEN_W-1:0]     s_arlen,
   output logic [`AXI_SIZE_W-1:0]    s_arsize,
   output logic [`AXI_BURST_W-1:0]   s_arburst,
   input  logic                      s_rvalid,
   output logic                      s_rready,
   input  logic [`AXI_ID_W:0]        s_rid,
   input  logic [`AXI_DATA_W-1:0]    s_rdata,
   input  logic [`AXI_RESP_W-1:0]    s_rresp,
   input  logic                      s_rlast
);

   localparam int CNT_W = $clog2(OST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OST_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic             lock_r;
   logic             grant_r;
   logic             prio_r;
   logic [CNT_W-1:0] ost_cnt0_r;
   logic [CNT_W-1:0] ost_cnt1_r;

   logic m0_elig_s;
   logic m1_elig_s;
   logic win_s;
   logic grant_s;
   logic ar_hs_s;
   logic r_idx_s;
   logic r_done_s;

   // Counter step: +1 on accepted AR, -1 on final beat, both cancel; never below zero.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
      logic [CNT_W-1:0] res;
      res = cnt;
      case ({inc, dec})
         2'b10:   res = cnt + CNT_ONE;
         2'b01: begin
            if (cnt != CNT_ZERO) res = cnt - CNT_ONE;
            else                 res = cnt;
         end
         default: res = cnt;
      endcase
      return res;
   endfunction

   // AR arbitration, grant selection and payload mux.
   always_comb begin
      m0_elig_s = m0_arvalid & (ost_cnt0_r != CNT_MAX);
      m1_elig_s = m1_arvalid & (ost_cnt1_r != CNT_MAX);
      win_s     = 1'b0;
      if (m0_elig_s & m1_elig_s) win_s = prio_r;
      else if (m1_elig_s)        win_s = 1'b1;
      else                       win_s = 1'b0;
      // A pending, unaccepted request keeps its grant so the payload stays stable.
      grant_s    = lock_r ? grant_r : win_s;
      s_arvalid  = lock_r | m0_elig_s | m1_elig_s;
      ar_hs_s    = s_arvalid & s_arready;
      m0_arready = ar_hs_s & (grant_s == 1'b0);
      m1_arready = ar_hs_s & (grant_s == 1'b1);
      s_arid     = {grant_s, (grant_s ? m1_arid : m0_arid)};
      s_araddr   = grant_s ? m1_araddr  : m0_araddr;
      s_arlen    = grant_s ? m1_arlen   : m0_arlen;
      s_arsize   = grant_s ? m1_arsize  : m0_arsize;
      s_arburst  = grant_s ? m1_arburst : m0_arburst;
   end

   // R routing by the ID tag bit; data fields are broadcast to both masters.
   always_comb begin
      r_idx_s   = s_rid[`AXI_ID_W];
      m0_rvalid = s_rvalid & (r_idx_s == 1'b0);
      m1_rvalid = s_rvalid & (r_idx_s == 1'b1);
      s_rready  = r_idx_s ? m1_rready : m0_rready;
      r_done_s  = s_rvalid & s_rready & s_rlast;
      m0_rid    = s_rid[`AXI_ID_W-1:0];
      m1_rid    = s_rid[`AXI_ID_W-1:0];
      m0_rdata  = s_rdata;
      m1_rdata  = s_rdata;
      m0_rresp  = s_rresp;
      m1_rresp  = s_rresp;
      m0_rlast  = s_rlast;
      m1_rlast  = s_rlast;
   end

   // Lock, round-robin priority and outstanding counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_r     <= 1'b0;
         grant_r    <= 1'b0;
         prio_r     <= 1'b0;
         ost_cnt0_r <= CNT_ZERO;
         ost_cnt1_r <= CNT_ZERO;
      end else begin
         if (ar_hs_s) begin
            lock_r <= 1'b0;
            prio_r <= ~grant_s;
         end else if (s_arvalid) begin
            lock_r  <= 1'b1;
            grant_r <= grant_s;
         end else begin
            lock_r <= lock_r;
         end
         ost_cnt0_r <= cnt_next(ost_cnt0_r, ar_hs_s & ~grant_s, r_done_s & ~r_idx_s);
         ost_cnt1_r <= cnt_next(ost_cnt1_r, ar_hs_s &  grant_s, r_done_s &  r_idx_s);
      end
   end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_easyaxi_rd_arb
// Self-checking bench for easyaxi_rd_arb (OST_MAX=2). A behavioural model
// keeps per-master outstanding counts, whose turn it is, and which master
// owns a pending unaccepted request. Directed scenarios are followed by
// randomized traffic, including a reset in the middle of the run.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_arb;

   localparam int OST = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
   logic [`AXI_ID_W-1:0]    m0_arid, m1_arid, m0_rid, m1_rid;
   logic [`AXI_ADDR_W-1:0]  m0_araddr, m1_araddr, s_araddr;
   logic [`AXI_LEN_W-1:0]   m0_arlen, m1_arlen, s_arlen;
   logic [`AXI_SIZE_W-1:0]  m0_arsize, m1_arsize, s_arsize;
   logic [`AXI_BURST_W-1:0] m0_arburst, m1_arburst, s_arburst;
   logic m0_rvalid, m0_rready, m1_rvalid, m1_rready, m0_rlast, m1_rlast;
   logic [`AXI_DATA_W-1:0]  m0_rdata, m1_rdata, s_rdata;
   logic [`AXI_RESP_W-1:0]  m0_rresp, m1_rresp, s_rresp;
   logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [`AXI_ID_W:0]      s_arid, s_rid;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int cnt [2];
   int prio;
   int held;          // -1: no pending request, else owner of the pending request
   int exp_g;
   bit exp_ar_hs;
   bit exp_r_done;
   int exp_idx;

   easyaxi_rd_arb #(.OST_MAX(OST)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      m0_arvalid = 1'b0; m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
      m1_arvalid = 1'b0; m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
      m0_rready = 1'b0; m1_rready = 1'b0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
   endtask

   task automatic model_reset();
      cnt[0] = 0; cnt[1] = 0; prio = 0; held = -1;
   endtask

   // Compare every output against the model for the current inputs.
   task automatic sample();
      bit e0, e1, sv;
      logic [`AXI_ID_W:0] eid;
      @(negedge clk);
      e0 = m0_arvalid && (cnt[0] < OST);
      e1 = m1_arvalid && (cnt[1] < OST);
      if (held >= 0)     exp_g = held;
      else if (e0 && e1) exp_g = prio;
      else if (e1)       exp_g = 1;
      else               exp_g = 0;
      sv = (held >= 0) || e0 || e1;
      exp_ar_hs = sv && s_arready;
      chk("s_arvalid", s_arvalid, sv);
      chk("m0_arready", m0_arready, exp_ar_hs && exp_g == 0);
      chk("m1_arready", m1_arready, exp_ar_hs && exp_g == 1);
      if (sv) begin
         eid = (exp_g == 1) ? {1'b1, m1_arid} : {1'b0, m0_arid};
         chk("s_arid", s_arid, eid);
         chk("s_araddr", s_araddr, (exp_g == 1) ? m1_araddr : m0_araddr);
         chk("s_arlen", s_arlen, (exp_g == 1) ? m1_arlen : m0_arlen);
         chk("s_arsize", s_arsize, (exp_g == 1) ? m1_arsize : m0_arsize);
         chk("s_arburst", s_arburst, (exp_g == 1) ? m1_arburst : m0_arburst);
      end
      exp_idx = s_rid[`AXI_ID_W] ? 1 : 0;
      chk("m0_rvalid", m0_rvalid, s_rvalid && exp_idx == 0);
      chk("m1_rvalid", m1_rvalid, s_rvalid && exp_idx == 1);
      chk("s_rready", s_rready, (exp_idx == 1) ? m1_rready : m0_rready);
      exp_r_done = s_rvalid && s_rlast && ((exp_idx == 1) ? m1_rready : m0_rready);
      chk("m0_rid", m0_rid, s_rid[`AXI_ID_W-1:0]);
      chk("m1_rid", m1_rid, s_rid[`AXI_ID_W-1:0]);
      chk("m0_rdata", m0_rdata, s_rdata);
      chk("m1_rdata", m1_rdata, s_rdata);
      chk("m0_rresp", m0_rresp, s_rresp);
      chk("m1_rlast", m1_rlast, s_rlast);
   endtask

   // Apply the clock edge to the model, then move past it.
   task automatic advance();
      if (rst_n) begin
         if (exp_ar_hs) begin
            cnt[exp_g]++;
            prio = 1 - exp_g;
            held = -1;
         end else if ((held >= 0) || (m0_arvalid && cnt[0] < OST) || (m1_arvalid && cnt[1] < OST)) begin
            held = exp_g;
         end
         if (exp_r_done && cnt[exp_idx] > 0) cnt[exp_idx]--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      sample();
      chk("rst_s_arvalid", s_arvalid, 1'b0);
      chk("rst_arready", {m0_arready, m1_arready}, 2'b00);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      chk("rst_s_rready", s_rready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic r_beat(input logic [`AXI_ID_W:0] id, input logic last);
      s_rvalid = 1'b1; s_rid = id; s_rlast = last; s_rdata = $urandom;
      m0_rready = 1'b1; m1_rready = 1'b1;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      #1;
      do_reset();

      // Single master: AR id 3, four beats back.
      m0_arvalid = 1'b1; m0_arid = 4'h3; m0_araddr = 32'h10; m0_arlen = 8'd3; s_arready = 1'b1;
      sample();
      chk("single_arid", s_arid, 5'h03);
      chk("single_arready", m0_arready, 1'b1);
      advance();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         r_beat(5'h03, (i == 3));
         sample();
         chk("single_m0_rvalid", m0_rvalid, 1'b1);
         chk("single_m1_rvalid", m1_rvalid, 1'b0);
         chk("single_m0_rid", m0_rid, 4'h3);
         advance();
      end
      clear_inputs();

      // Contention: alternating grants starting with m0.
      do_reset();
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_arid = 4'h1; m1_arid = 4'h2; s_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("contend_tag", s_arid[`AXI_ID_W], i % 2);
         advance();
      end

      // Lock: m1 granted and held while m0 waits and changes payload.
      do_reset();
      m0_arvalid = 1'b1; s_arready = 1'b1;            // m0 takes a turn so prio passes to m1
      step();
      clear_inputs();
      r_beat(5'h00, 1'b1);
      step();
      clear_inputs();
      m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_araddr = 32'hABCD_0000; m1_arid = 4'h7;
      for (int i = 0; i < 3; i++) begin
         m0_araddr = $urandom;
         sample();
         chk("lock_tag", s_arid[`AXI_ID_W], 1'b1);
         chk("lock_addr", s_araddr, 32'hABCD_0000);
         chk("lock_valid", s_arvalid, 1'b1);
         advance();
      end
      s_arready = 1'b1;
      sample();
      chk("lock_hs_m1", m1_arready, 1'b1);
      advance();
      m1_arvalid = 1'b0;
      sample();
      chk("lock_next_m0", m0_arready, 1'b1);
      advance();

      // Throttle: third AR blocked until an rlast for tag 0.
      do_reset();
      m0_arvalid = 1'b1; s_arready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) r_beat(5'h00, 1'b1);
         sample();
         chk("throttle_arready", m0_arready, (i < 2));
         advance();
      end
      s_rvalid = 1'b0;
      sample();
      chk("throttle_unblock", m0_arready, 1'b1);
      advance();

      // Simultaneous AR and final beat on m1 leave its count unchanged.
      do_reset();
      m1_arvalid = 1'b1; s_arready = 1'b1;
      step();                                  // count 1
      r_beat(5'h10, 1'b1);
      sample();
      chk("simul_arready", m1_arready, 1'b1);
      advance();                               // count stays 1
      s_rvalid = 1'b0;
      sample();
      chk("simul_after", m1_arready, 1'b1);
      advance();                               // count 2
      sample();
      chk("simul_full", m1_arready, 1'b0);
      advance();
      clear_inputs();

      // Routing under backpressure.
      do_reset();
      s_rvalid = 1'b1; s_rid = 5'h15; s_rdata = 32'h1234_5678; m1_rready = 1'b0; m0_rready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("bp_s_rready", s_rready, 1'b0);
         chk("bp_m0_rvalid", m0_rvalid, 1'b0);
         chk("bp_m1_rvalid", m1_rvalid, 1'b1);
         chk("bp_m1_rid", m1_rid, 4'h5);
         advance();
      end
      m1_rready = 1'b1;
      sample();
      chk("bp_release", s_rready, 1'b1);
      advance();
      clear_inputs();

      // Randomized traffic with a reset in the middle.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (c == 700) do_reset();
         m0_arvalid = ($urandom_range(0, 3) != 0);
         m1_arvalid = ($urandom_range(0, 2) != 0);
         m0_arid = $urandom; m1_arid = $urandom;
         m0_araddr = $urandom; m1_araddr = $urandom;
         m0_arlen = $urandom; m1_arlen = $urandom;
         m0_arsize = $urandom; m1_arsize = $urandom;
         m0_arburst = $urandom; m1_arburst = $urandom;
         s_arready = ($urandom_range(0, 1) != 0);
         s_rvalid = ($urandom_range(0, 1) != 0);
         s_rid = $urandom; s_rdata = $urandom; s_rresp = $urandom;
         s_rlast = ($urandom_range(0, 2) == 0);
         m0_rready = ($urandom_range(0, 3) != 0);
         m1_rready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/easyaxi_rd_arb.md
# easyaxi_rd_arb

Two-master AXI read-channel arbiter that shares one downstream AXI slave read port between two EASYAXI read masters. It arbitrates the AR channel round-robin, tags each forwarded request with the source master index in the ID MSB, and routes R beats back to the owning master by that bit. Per-master outstanding counters throttle each master independently. It sits between the master instances and the slave/interconnect port.

## Interface
- OST_MAX, 16, max outstanding bursts per master (1..255); counter width is $clog2(OST_MAX+1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- m0_arvalid/m1_arvalid  in  1  master AR valid.
- m0_arready/m1_arready  out  1  master AR ready.
- m0_arid/m1_arid  in  `AXI_ID_W  master AR ID.
- m0_araddr/m1_araddr  in  `AXI_ADDR_W  address.
- m0_arlen/m1_arlen  in  `AXI_LEN_W  burst length.
- m0_arsize/m1_arsize  in  `AXI_SIZE_W  size.
- m0_arburst/m1_arburst  in  `AXI_BURST_W  burst type.
- m0_rvalid/m1_rvalid  out  1  routed R valid.
- m0_rready/m1_rready  in  1  master R ready.
- m0_rid/m1_rid  out  `AXI_ID_W  R ID with tag bit stripped.
- m0_rdata/m1_rdata  out  `AXI_DATA_W  read data (broadcast).
- m0_rresp/m1_rresp  out  `AXI_RESP_W  response (broadcast).
- m0_rlast/m1_rlast  out  1  last beat (broadcast).
- s_arvalid  out  1  downstream AR valid.
- s_arready  in  1  downstream AR ready.
- s_arid  out  `AXI_ID_W+1  {grant index, master arid}.
- s_araddr/s_arlen/s_arsize/s_arburst  out  AXI widths  muxed payload.
- s_rvalid  in  1  downstream R valid.
- s_rready  out  1  downstream R ready.
- s_rid  in  `AXI_ID_W+1  tagged R ID.
- s_rdata/s_rresp/s_rlast  in  AXI widths  R payload.

## Operation
- Eligibility: mN_elig = mN_arvalid & (ost_cnt_N != OST_MAX).
- Arbitration (when lock_r=0): one eligible master wins; both eligible -> master at prio_r wins. prio_r resets to 0.
- Grant: grant = lock_r ? grant_r : arbitration winner. s_arvalid = lock_r | any eligible. Payload muxed from the granted master; s_arid = {grant, mN_arid}.
- Lock: if s_arvalid & ~s_arready, set lock_r=1, grant_r=grant. Clear on handshake. While locked, no re-arbitration and the payload is held stable, even if the other master becomes eligible.
- mN_arready = s_arready & s_arvalid & (grant==N). The non-granted master sees 0.
- On AR handshake: prio_r <= ~grant. ost_cnt_grant += 1.
- R routing: idx = s_rid[`AXI_ID_W]. m_idx_rvalid = s_rvalid; the other master's rvalid = 0. s_rready = m_idx_rready. mN_rid = s_rid[`AXI_ID_W-1:0].
- On R handshake with s_rlast: ost_cnt_idx -= 1.
- Simultaneous increment and decrement on the same counter: value unchanged.
- A decrement at 0 is impossible by protocol. The counter saturates at 0 and does not underflow.
- The counter never exceeds OST_MAX, because an ineligible master is never granted; a locked grant was already counted as eligible.

## Timing
- Reset values: lock_r=0, grant_r=0, prio_r=0, ost_cnt_0=ost_cnt_1=0.
- With all inputs low, every valid/ready output is 0.
- AR path is combinational: zero-cycle latency from mN_arvalid to s_arvalid. The handshake completes in the same cycle as s_arready.
- R path is fully combinational: zero latency, no buffering.
- Counter, prio, and lock updates take effect on the next clk edge.
- A counter reaching OST_MAX blocks that master from the following cycle. A same-cycle rlast decrement re-enables it the next cycle.
- Back-to-back AR from one master is allowed every cycle when the other master is idle.
- Reset mid-burst: all state clears immediately. Outstanding tracking is lost; upstream and downstream must be reset together.

## Test plan
- Single master: m0 issues arid=3, araddr=0x10, arlen=3 -> s_arid=0x03 (tag 0), and four R beats route to m0 only with m0_rid=3. ost_cnt_0 goes 0->1->0 after rlast.
- Contention: m0 and m1 both valid every cycle with s_arready=1 -> grants alternate m0,m1,m0,m1, starting with m0 after reset.
- Lock: m1 granted, s_arready held low 3 cycles while m0 is also valid -> s_arvalid stays 1 with m1 payload stable. Grant goes to m0 the cycle after the handshake.
- Throttle: OST_MAX=2, m0 issues 3 ARs with no R returned -> third AR is blocked (m0_arready=0). An rlast for tag 0 unblocks it on the next cycle.
- Simultaneous: an AR handshake and a final rlast for m1 in the same cycle -> ost_cnt_1 is unchanged.
- Routing under backpressure: s_rid tag=1 with m1_rready=0 -> s_rready=0, m0_rvalid=0, and the beat is held until m1_rready=1.
